// File: rtl/pipeline_run_ctl.sv
// Debug run/stop controller: debounced buttons drive a HALT/RUN/STEP/BURST FSM that gates the pipeline clock enable.
// Optional breakpoint slots and PC compare are built when PIPELINE_RUN_CTL_BP_EN is defined.
module prc_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]       sync;
  logic             filt;
  logic [CNT_W-1:0] cnt;

  // cnt tracks consecutive samples that disagree with the filtered level
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync    <= '0;
      filt    <= 1'b0;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync    <= {sync[0], i_btn};
      o_press <= 1'b0;
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        cnt     <= '0;
        filt    <= sync[1];
        o_press <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module pipeline_run_ctl #(
  parameter  int XLEN      = 32,
  parameter  int NUM_BP    = 4,
  parameter  int STEP_W    = 8,
  parameter  int DB_CYCLES = 16,
  localparam int IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_btn_run,
  input  logic              i_btn_step,
  input  logic [1:0]        i_mode,
  input  logic [STEP_W-1:0] i_step_count,
  input  logic [XLEN-1:0]   i_pc_d,
  input  logic              i_bp_wr_en,
  input  logic [IDX_W-1:0]  i_bp_idx,
  input  logic [XLEN-1:0]   i_bp_addr,
  input  logic              i_bp_valid,
  output logic              o_clk_en,
  output logic              o_halted,
  output logic              o_bp_hit,
  output logic [IDX_W-1:0]  o_bp_hit_idx,
  output logic [31:0]       o_cycle_cnt
);
  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_BURST} state_t;

  state_t            state, state_nx;
  logic [1:0]        press;
  logic              run_p, step_p, bp_stop, bp_match, leave_halt;
  logic [STEP_W-1:0] burst_cnt;

  prc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [1:0] (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   ({i_btn_step, i_btn_run}),
    .o_press (press)
  );
  assign run_p  = press[0];
  assign step_p = press[1];

  assign o_clk_en   = (state != S_HALT);
  assign o_halted   = (state == S_HALT);
  assign leave_halt = (state == S_HALT) && (state_nx != S_HALT);

  // run wins over a coincident step press, whatever the mode
  always_comb begin
    state_nx = state;
    bp_stop  = 1'b0;
    case (state)
      S_HALT: begin
        if (run_p && (i_mode == 2'b00 || i_mode == 2'b11 || step_p))
          state_nx = S_RUN;
        else if (step_p && i_mode == 2'b01)
          state_nx = S_STEP;
        else if (step_p && i_mode == 2'b10 && i_step_count != '0)
          state_nx = S_BURST;
      end
      S_RUN: begin
        if (run_p) begin
          state_nx = S_HALT;
        end else if (bp_match) begin
          state_nx = S_HALT;
          bp_stop  = 1'b1;
        end
      end
      S_STEP:  state_nx = S_HALT;
      S_BURST: if (run_p || burst_cnt == STEP_W'(1)) state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_HALT;
      burst_cnt   <= '0;
      o_cycle_cnt <= '0;
    end else begin
      state       <= state_nx;
      o_cycle_cnt <= o_cycle_cnt + 32'(o_clk_en);
      if (state == S_HALT && state_nx == S_BURST)
        burst_cnt <= i_step_count;
      else if (state == S_BURST)
        burst_cnt <= (state_nx == S_HALT) ? '0 : burst_cnt - STEP_W'(1);
    end
  end

`ifdef PIPELINE_RUN_CTL_BP_EN
  logic [NUM_BP-1:0][XLEN-1:0] bp_addr;
  logic [NUM_BP-1:0]           bp_vld, hit_vec;
  logic [IDX_W-1:0]            hit_idx;
  logic [1:0]                  mode_q;
  logic                        first_q;

  for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
    assign hit_vec[g] = bp_vld[g] && (bp_addr[g] == i_pc_d);
  end

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (hit_vec[i]) hit_idx = IDX_W'(i);
  end

  // first_q masks the compare on the cycle that resumes from a breakpoint PC
  assign bp_match = (mode_q == 2'b11) && !first_q && (|hit_vec);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bp_addr      <= '0;
      bp_vld       <= '0;
      mode_q       <= 2'b00;
      first_q      <= 1'b0;
      o_bp_hit     <= 1'b0;
      o_bp_hit_idx <= '0;
    end else begin
      first_q <= (state == S_HALT) && (state_nx == S_RUN);
      if (leave_halt) mode_q <= i_mode;
      if (i_bp_wr_en && 32'(i_bp_idx) < NUM_BP) begin
        bp_addr[i_bp_idx] <= i_bp_addr;
        bp_vld[i_bp_idx]  <= i_bp_valid;
      end
      if (leave_halt) begin
        o_bp_hit     <= 1'b0;
        o_bp_hit_idx <= '0;
      end else if (bp_stop) begin
        o_bp_hit     <= 1'b1;
        o_bp_hit_idx <= hit_idx;
      end
    end
  end
`else
  logic unused_bp;
  assign unused_bp    = ^{i_pc_d, i_bp_wr_en, i_bp_idx, i_bp_addr, i_bp_valid, bp_stop, leave_halt};
  assign bp_match     = 1'b0;
  assign o_bp_hit     = 1'b0;
  assign o_bp_hit_idx = '0;
`endif
endmodule

// File: tb/tb_pipeline_run_ctl.sv
// Directed bench for pipeline_run_ctl: debounce, step/burst/run modes, breakpoints and async reset.
module tb_pipeline_run_ctl;
  localparam int XLEN = 32, NUM_BP = 4, STEP_W = 8, DB = 16, IDX_W = 2;
  localparam int LAT = DB + 3; // button edge -> 2 sync flops -> DB samples -> FSM edge

  logic              i_clk = 1'b0, i_rst = 1'b0;
  logic              i_btn_run = 1'b0, i_btn_step = 1'b0;
  logic [1:0]        i_mode = 2'b00;
  logic [STEP_W-1:0] i_step_count = '0;
  logic [XLEN-1:0]   i_pc_d = '0, i_bp_addr = '0;
  logic              i_bp_wr_en = 1'b0, i_bp_valid = 1'b0;
  logic [IDX_W-1:0]  i_bp_idx = '0;
  logic              o_clk_en, o_halted, o_bp_hit;
  logic [IDX_W-1:0]  o_bp_hit_idx;
  logic [31:0]       o_cycle_cnt;

  int n_cmp = 0, n_err = 0;
  int highs, max_run, run_len, n;

  pipeline_run_ctl #(.XLEN(XLEN), .NUM_BP(NUM_BP), .STEP_W(STEP_W), .DB_CYCLES(DB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn_run(i_btn_run), .i_btn_step(i_btn_step),
    .i_mode(i_mode), .i_step_count(i_step_count), .i_pc_d(i_pc_d),
    .i_bp_wr_en(i_bp_wr_en), .i_bp_idx(i_bp_idx), .i_bp_addr(i_bp_addr), .i_bp_valid(i_bp_valid),
    .o_clk_en(o_clk_en), .o_halted(o_halted), .o_bp_hit(o_bp_hit),
    .o_bp_hit_idx(o_bp_hit_idx), .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge i_clk);
  endtask

  task automatic clr();
    highs = 0; max_run = 0; run_len = 0;
  endtask

  task automatic watch(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge i_clk);
      if (o_clk_en) begin
        highs++; run_len++;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;
    end
  endtask

  // returns number of cycles until o_clk_en == v; bound+1 on timeout
  task automatic wait_en(input logic v, input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge i_clk);
      cyc++;
    end while (o_clk_en !== v && cyc <= bound);
  endtask

  task automatic stop_run(input string tag);
    int c;
    i_btn_run = 1'b1;
    wait_en(1'b0, 40, c);
    chk(tag, c, LAT);
    i_btn_run = 1'b0;
    tick(25);
  endtask

  task automatic start_run(input string tag);
    int c;
    i_btn_run = 1'b1;
    wait_en(1'b1, 40, c);
    chk(tag, c, LAT);
    i_btn_run = 1'b0;
  endtask

  task automatic bp_wr(input int idx, input logic [31:0] a, input logic v);
    i_bp_wr_en = 1'b1; i_bp_idx = IDX_W'(idx); i_bp_addr = a; i_bp_valid = v;
    tick(1);
    i_bp_wr_en = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_clk_en", o_clk_en, 0);
    chk("rst_halted", o_halted, 1);
    chk("rst_bp_hit", o_bp_hit, 0);
    chk("rst_bp_idx", o_bp_hit_idx, 0);
    chk("rst_cycle_cnt", o_cycle_cnt, 0);
    i_rst = 1'b1;
    tick(2);

    // 3-cycle glitch is filtered out
    clr(); i_btn_run = 1'b1; tick(3); i_btn_run = 1'b0;
    watch(40);
    chk("glitch_highs", highs, 0);
    chk("glitch_cnt", o_cycle_cnt, 0);

    // single step, button held 40 cycles
    i_mode = 2'b01; clr(); i_btn_step = 1'b1; watch(40); i_btn_step = 1'b0; watch(25);
    chk("step_highs", highs, 1);
    chk("step_cnt", o_cycle_cnt, 1);
    chk("step_halted", o_halted, 1);

    // burst of 5
    i_mode = 2'b10; i_step_count = 8'd5; clr();
    i_btn_step = 1'b1; watch(30); i_btn_step = 1'b0; watch(25);
    chk("burst_highs", highs, 5);
    chk("burst_run", max_run, 5);
    chk("burst_halted", o_halted, 1);
    chk("burst_cnt", o_cycle_cnt, 6);

    // burst of 0 does nothing
    i_step_count = 8'd0; clr();
    i_btn_step = 1'b1; watch(30); i_btn_step = 1'b0; watch(25);
    chk("burst0_highs", highs, 0);
    chk("burst0_cnt", o_cycle_cnt, 6);

    // free-run; mode change while running is ignored
    i_mode = 2'b00;
    start_run("run_lat");
    i_mode = 2'b01; tick(25);
    chk("run_mode_ignored", o_clk_en, 1);
    stop_run("run_stop_lat");
    chk("run_stop_halted", o_halted, 1);

    // run and step together in mode 01 -> run
    i_btn_step = 1'b1;
    start_run("both_lat");
    i_btn_step = 1'b0; tick(25);
    chk("both_running", o_clk_en, 1);
    stop_run("both_stop_lat");

`ifdef PIPELINE_RUN_CTL_BP_EN
    bp_wr(2, 32'h40, 1'b1);
    bp_wr(0, 32'h40, 1'b1);
    i_pc_d = 32'h10; i_mode = 2'b11;
    start_run("bp_run_lat");
    tick(3);
    chk("bp_running", o_clk_en, 1);
    i_pc_d = 32'h40; tick(1);
    chk("bp_halt", o_clk_en, 0);
    chk("bp_hit", o_bp_hit, 1);
    chk("bp_idx_low", o_bp_hit_idx, 0);
    tick(25);
    chk("bp_hit_sticky", o_bp_hit, 1);
    start_run("bp_resume_lat");
    chk("bp_hit_clr", o_bp_hit, 0);
    tick(1);
    chk("bp_resume_past", o_clk_en, 1);
    i_pc_d = 32'h44; tick(25);
    chk("bp_resume_run", o_clk_en, 1);
    stop_run("bp_stop_lat");
    bp_wr(0, 32'h40, 1'b0);
    start_run("bp_run2_lat");
    tick(25);
    i_pc_d = 32'h40; tick(1);
    chk("bp2_halt", o_clk_en, 0);
    chk("bp2_idx", o_bp_hit_idx, 2);
    i_pc_d = 32'h0; tick(25);
`else
    bp_wr(0, 32'h40, 1'b1);
    i_pc_d = 32'h40; i_mode = 2'b11;
    start_run("m11_run_lat");
    tick(25);
    chk("m11_no_bp", o_clk_en, 1);
    chk("m11_bp_hit", o_bp_hit, 0);
    stop_run("m11_stop_lat");
    i_pc_d = 32'h0;
`endif

    // async reset in the middle of a burst
    i_mode = 2'b10; i_step_count = 8'd8;
    i_btn_step = 1'b1;
    wait_en(1'b1, 40, n);
    chk("rb_lat", n, LAT);
    tick(4);
    chk("rb_running", o_clk_en, 1);
    #1 i_rst = 1'b0;
    #1;
    chk("rb_clk_en_async", o_clk_en, 0);
    chk("rb_halted_async", o_halted, 1);
    chk("rb_cnt_async", o_cycle_cnt, 0);
    i_btn_step = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1; clr();
    watch(30);
    chk("rb_after_highs", highs, 0);
    chk("rb_after_cnt", o_cycle_cnt, 0);
    chk("rb_after_halted", o_halted, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
